// File: rtl/udp_chan_router.sv
// Routes a UDP payload stream to per-channel ring buffers selected by a 32-bit leading flag:
// one write command per packet, then payload packed little-endian into output words.
module udp_chan_router #(
    parameter int NUM_CH = 4,
    parameter int C_AXI_DATA_WIDTH = 16,
    parameter logic [NUM_CH*32-1:0] FLAG_TABLE = 128'hDD30DD30_DDC00264_AD8686DA_E1EC0C0D,
    parameter logic [NUM_CH*32-1:0] BASE_TABLE = 128'hC0000000_80000000_40000000_00000000,
    parameter int REGION_AW = 16,
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DW = C_AXI_DATA_WIDTH,
    localparam int NB = C_AXI_DATA_WIDTH / 8
) (
    input  logic            clk_125m,
    input  logic            sys_rst_n,
    input  logic [7:0]      s_rx_data,
    input  logic            s_rx_valid,
    input  logic            s_rx_last,
    input  logic            s_rx_user,
    output logic            s_rx_ready,
    output logic [31:0]     cmd_addr,
    output logic [CHW-1:0]  cmd_ch,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [DW-1:0]   m_data,
    output logic [NB-1:0]   m_strb,
    output logic            m_last,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            done_valid,
    output logic            done_err,
    output logic [15:0]     drop_cnt,
    output logic [15:0]     err_cnt
);
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [31:0] WORD_BYTES = 32'(NB);

    typedef enum logic [2:0] {IDLE, FLAG, CMD, DATA, DROP} state_t;

    state_t               state;
    logic                 rdy_en;
    logic [1:0]           fcnt;
    logic [23:0]          flag_sr;
    logic [CHW-1:0]       ch_q;
    logic [REGION_AW-1:0] off [NUM_CH];
    logic [DW-1:0]        acc;
    logic [LW-1:0]        lane;
    logic [31:0]          words;
    logic                 ending;
    logic                 err_q;
    logic                 zdone;
    logic                 zerr;

    logic                 rx_fire;
    logic                 hs_last;
    logic                 word_done;
    logic                 hit;
    logic [CHW-1:0]       hit_ch;
    logic [31:0]          flag_full;
    logic [DW-1:0]        acc_nx;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [NB-1:0] strb_mask(input logic [LW-1:0] l);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) m[i] = (i <= int'(l));
        return m;
    endfunction

    assign flag_full  = {flag_sr, s_rx_data};
    assign rx_fire    = s_rx_valid & s_rx_ready;
    assign hs_last    = m_valid & m_ready & m_last;
    assign acc_nx     = acc | (DW'(s_rx_data) << {lane, 3'b000});
    assign word_done  = (lane == LW'(NB - 1)) || s_rx_last;
    assign done_valid = zdone | hs_last;
    assign done_err   = (zdone & zerr) | (hs_last & err_q);

    // Descending scan so the lowest matching channel index is the one left standing.
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (FLAG_TABLE[i*32 +: 32] == flag_full) begin
                hit    = 1'b1;
                hit_ch = CHW'(i);
            end
        end
    end

    // Once the last byte sits in the output register the packet is closed to further input.
    always_comb begin
        s_rx_ready = 1'b0;
        case (state)
            IDLE, FLAG, DROP: s_rx_ready = rdy_en;
            DATA:             s_rx_ready = !ending && (!m_valid || m_ready);
            default:          s_rx_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk_125m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            rdy_en    <= 1'b0;
            fcnt      <= '0;
            flag_sr   <= '0;
            ch_q      <= '0;
            acc       <= '0;
            lane      <= '0;
            words     <= '0;
            ending    <= 1'b0;
            err_q     <= 1'b0;
            zdone     <= 1'b0;
            zerr      <= 1'b0;
            cmd_addr  <= '0;
            cmd_ch    <= '0;
            cmd_valid <= 1'b0;
            m_data    <= '0;
            m_strb    <= '0;
            m_last    <= 1'b0;
            m_valid   <= 1'b0;
            drop_cnt  <= '0;
            err_cnt   <= '0;
            for (int i = 0; i < NUM_CH; i++) off[i] <= '0;
        end else begin
            rdy_en <= 1'b1;
            zdone  <= 1'b0;
            zerr   <= 1'b0;
            if (m_valid && m_ready) m_valid <= 1'b0;

            case (state)
                IDLE, FLAG: begin
                    if (rx_fire) begin
                        flag_sr <= {flag_sr[15:0], s_rx_data};
                        if (fcnt == 2'd3) begin
                            fcnt <= '0;
                            if (!hit) begin
                                drop_cnt <= sat_inc(drop_cnt);
                                state    <= s_rx_last ? IDLE : DROP;
                            end else if (s_rx_last) begin
                                state <= IDLE;
                                zdone <= 1'b1;
                                zerr  <= s_rx_user;
                                if (s_rx_user) err_cnt <= sat_inc(err_cnt);
                            end else begin
                                state     <= CMD;
                                cmd_valid <= 1'b1;
                                cmd_addr  <= BASE_TABLE[int'(hit_ch)*32 +: 32] + 32'(off[hit_ch]);
                                cmd_ch    <= hit_ch;
                                ch_q      <= hit_ch;
                            end
                        end else if (s_rx_last) begin
                            fcnt     <= '0;
                            state    <= IDLE;
                            drop_cnt <= sat_inc(drop_cnt);
                        end else begin
                            fcnt  <= fcnt + 2'd1;
                            state <= FLAG;
                        end
                    end
                end

                CMD: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= DATA;
                        acc       <= '0;
                        lane      <= '0;
                        words     <= '0;
                        ending    <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end

                DATA: begin
                    if (rx_fire) begin
                        if (word_done) begin
                            m_data  <= acc_nx;
                            m_strb  <= strb_mask(lane);
                            m_last  <= s_rx_last;
                            m_valid <= 1'b1;
                            words   <= words + 32'd1;
                            acc     <= '0;
                            lane    <= '0;
                            if (s_rx_last) begin
                                ending <= 1'b1;
                                err_q  <= s_rx_user;
                            end
                        end else begin
                            acc  <= acc_nx;
                            lane <= lane + 1'b1;
                        end
                    end
                    // Ring offset advances by whole words only for packets that completed cleanly.
                    if (hs_last) begin
                        state  <= IDLE;
                        ending <= 1'b0;
                        if (err_q) err_cnt <= sat_inc(err_cnt);
                        else       off[ch_q] <= off[ch_q] + REGION_AW'(words * WORD_BYTES);
                    end
                end

                DROP: begin
                    if (rx_fire && s_rx_last) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_chan_router.sv
// Directed bench for udp_chan_router: flag routing, word packing, ring offsets, drops, errors, reset.
module tb_udp_chan_router;
    localparam int DW = 16;
    localparam int AW = 8;

    logic        clk_125m = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  s_rx_data = '0;
    logic        s_rx_valid = 1'b0;
    logic        s_rx_last = 1'b0;
    logic        s_rx_user = 1'b0;
    logic        s_rx_ready;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_ch;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [15:0] m_data;
    logic [1:0]  m_strb;
    logic        m_last;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        done_valid;
    logic        done_err;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;

    udp_chan_router #(.REGION_AW(AW)) dut (
        .clk_125m(clk_125m), .sys_rst_n(sys_rst_n),
        .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid), .s_rx_last(s_rx_last),
        .s_rx_user(s_rx_user), .s_rx_ready(s_rx_ready),
        .cmd_addr(cmd_addr), .cmd_ch(cmd_ch), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .m_data(m_data), .m_strb(m_strb), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .done_valid(done_valid), .done_err(done_err),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #4 clk_125m = ~clk_125m;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_viol = 0;
    int stab_viol = 0;

    bit tog = 0;
    bit hold = 0;
    bit rnd_cmd = 0;

    logic [7:0]  pkt[$];
    logic [31:0] cq_addr[$];
    int          cq_ch[$];
    logic [15:0] wq_data[$];
    logic [1:0]  wq_strb[$];
    logic        wq_last[$];
    logic        dq_err[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output-side handshake drivers.
    initial begin
        forever begin
            @(posedge clk_125m);
            #1;
            if (hold)     m_ready = 1'b0;
            else if (tog) m_ready = ~m_ready;
            else          m_ready = 1'b1;
            cmd_ready = rnd_cmd ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    // Monitor, sampled mid-cycle.
    logic        pv, pr, pl, pcv, pcr;
    logic [15:0] pd;
    logic [1:0]  ps;
    logic [31:0] pca;
    always @(negedge clk_125m) begin
        if (!sys_rst_n) begin
            pv = 1'b0;
            pcv = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                cq_addr.push_back(cmd_addr);
                cq_ch.push_back(int'(cmd_ch));
            end
            if (m_valid && m_ready) begin
                wq_data.push_back(m_data);
                wq_strb.push_back(m_strb);
                wq_last.push_back(m_last);
            end
            if (done_valid) dq_err.push_back(done_err);
            if (m_valid && !m_ready && s_rx_ready) rdy_viol++;
            if (pv && !pr && (!m_valid || m_data !== pd || m_strb !== ps || m_last !== pl)) stab_viol++;
            if (pcv && !pcr && (!cmd_valid || cmd_addr !== pca)) stab_viol++;
            pv = m_valid; pr = m_ready; pd = m_data; ps = m_strb; pl = m_last;
            pcv = cmd_valid; pcr = cmd_ready; pca = cmd_addr;
        end
    end

    task automatic clear_q();
        cq_addr.delete(); cq_ch.delete();
        wq_data.delete(); wq_strb.delete(); wq_last.delete();
        dq_err.delete(); pkt.delete();
    endtask

    task automatic add_flag(input logic [31:0] f);
        pkt.push_back(f[31:24]); pkt.push_back(f[23:16]);
        pkt.push_back(f[15:8]);  pkt.push_back(f[7:0]);
    endtask

    task automatic add_seq(input logic [7:0] start, input int n);
        logic [7:0] b;
        b = start;
        for (int i = 0; i < n; i++) begin
            pkt.push_back(b);
            b = b + 8'd1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_125m);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the final byte is accepted.
    task automatic send(input bit with_last, input logic usr);
        int n;
        int k;
        n = pkt.size();
        for (int i = 0; i < n; i++) begin
            s_rx_data  = pkt[i];
            s_rx_valid = 1'b1;
            s_rx_last  = with_last && (i == n - 1);
            s_rx_user  = s_rx_last ? usr : 1'b0;
            k = 0;
            @(negedge clk_125m);
            while (!s_rx_ready && k < 200) begin
                k++;
                @(negedge clk_125m);
            end
            if (!s_rx_ready) chk("rx_stall", 32'(s_rx_ready), 32'd1);
            @(posedge clk_125m);
            #1;
        end
        s_rx_valid = 1'b0;
        s_rx_last  = 1'b0;
        s_rx_user  = 1'b0;
        pkt.delete();
    endtask

    task automatic chk_cmd(input string tag, input int i, input logic [31:0] a, input int ch);
        if (i < cq_addr.size()) begin
            chk($sformatf("%s_cmd%0d_addr", tag, i), cq_addr[i], a);
            chk($sformatf("%s_cmd%0d_ch", tag, i), 32'(cq_ch[i]), 32'(ch));
        end else chk($sformatf("%s_cmd_cnt", tag), 32'(cq_addr.size()), 32'(i + 1));
    endtask

    task automatic chk_word(input string tag, input int i, input logic [15:0] d,
                            input logic [1:0] s, input logic l);
        if (i < wq_data.size()) begin
            chk($sformatf("%s_w%0d_data", tag, i), 32'(wq_data[i]), 32'(d));
            chk($sformatf("%s_w%0d_strb", tag, i), 32'(wq_strb[i]), 32'(s));
            chk($sformatf("%s_w%0d_last", tag, i), 32'(wq_last[i]), 32'(l));
        end else chk($sformatf("%s_word_cnt", tag), 32'(wq_data.size()), 32'(i + 1));
    endtask

    task automatic chk_done(input string tag, input int n, input logic err);
        chk({tag, "_done_cnt"}, 32'(dq_err.size()), 32'(n));
        if (dq_err.size() > 0) chk({tag, "_done_err"}, 32'(dq_err[0]), 32'(err));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and ready release timing
        repeat (3) @(posedge clk_125m);
        #1;
        chk("rst_rdy", 32'(s_rx_ready), 0);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_done", 32'(done_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_err", 32'(err_cnt), 0);
        sys_rst_n = 1'b1;
        @(negedge clk_125m);
        chk("rel_rdy_early", 32'(s_rx_ready), 0);
        @(posedge clk_125m);
        #1;
        chk("rel_rdy", 32'(s_rx_ready), 1);

        // Channel 0, six bytes
        clear_q();
        add_flag(32'hE1EC0C0D); add_seq(8'h01, 6);
        send(1, 0); idle(6);
        chk_cmd("A", 0, 32'h0000_0000, 0);
        chk_word("A", 0, 16'h0201, 2'b11, 0);
        chk_word("A", 1, 16'h0403, 2'b11, 0);
        chk_word("A", 2, 16'h0605, 2'b11, 1);
        chk_done("A", 1, 0);
        clear_q();
        add_flag(32'hE1EC0C0D); pkt.push_back(8'h77);
        send(1, 0); idle(6);
        chk_cmd("A2", 0, 32'h0000_0006, 0);
        chk_word("A2", 0, 16'h0077, 2'b01, 1);

        // Channel 1, odd length
        clear_q();
        add_flag(32'hAD8686DA); pkt.push_back(8'hAA); pkt.push_back(8'hBB); pkt.push_back(8'hCC);
        send(1, 0); idle(6);
        chk_cmd("B", 0, 32'h4000_0000, 1);
        chk_word("B", 0, 16'hBBAA, 2'b11, 0);
        chk_word("B", 1, 16'h00CC, 2'b01, 1);
        clear_q();
        add_flag(32'hAD8686DA); pkt.push_back(8'h11); pkt.push_back(8'h22);
        send(1, 0); idle(6);
        chk_cmd("B2", 0, 32'h4000_0004, 1);
        chk_word("B2", 0, 16'h2211, 2'b11, 1);

        // Unmatched flag and short packet
        clear_q();
        add_flag(32'h12345678); add_seq(8'h50, 10);
        send(1, 0); idle(6);
        chk("C_cmd_cnt", 32'(cq_addr.size()), 0);
        chk("C_word_cnt", 32'(wq_data.size()), 0);
        chk("C_done_cnt", 32'(dq_err.size()), 0);
        chk("C_drop1", 32'(drop_cnt), 1);
        pkt.push_back(8'hE1); pkt.push_back(8'hEC);
        send(1, 0); idle(6);
        chk("C_drop2", 32'(drop_cnt), 2);

        // Matched flag with zero payload
        clear_q();
        add_flag(32'hDD30DD30);
        send(1, 0); idle(6);
        chk("Z_cmd_cnt", 32'(cq_addr.size()), 0);
        chk("Z_word_cnt", 32'(wq_data.size()), 0);
        chk_done("Z", 1, 0);
        chk("Z_drop", 32'(drop_cnt), 2);

        // Channel 3 ring wrap (2^8-byte ring)
        clear_q();
        add_flag(32'hDD30DD30); add_seq(8'h00, 252);
        send(1, 0); idle(6);
        add_flag(32'hDD30DD30); add_seq(8'h80, 8);
        send(1, 0); idle(6);
        add_flag(32'hDD30DD30); pkt.push_back(8'h99);
        send(1, 0); idle(6);
        chk_cmd("D", 0, 32'hC000_0000, 3);
        chk_cmd("D", 1, 32'hC000_00FC, 3);
        chk_cmd("D", 2, 32'hC000_0004, 3);

        // Backpressure on both the command and data sides
        clear_q();
        tog = 1; rnd_cmd = 1;
        idle(2);
        add_flag(32'hE1EC0C0D); add_seq(8'h10, 9);
        send(1, 0); idle(30);
        tog = 0; rnd_cmd = 0;
        idle(2);
        chk_cmd("E", 0, 32'h0000_0008, 0);
        chk_word("E", 0, 16'h1110, 2'b11, 0);
        chk_word("E", 1, 16'h1312, 2'b11, 0);
        chk_word("E", 2, 16'h1514, 2'b11, 0);
        chk_word("E", 3, 16'h1716, 2'b11, 0);
        chk_word("E", 4, 16'h0018, 2'b01, 1);
        chk("E_word_cnt", 32'(wq_data.size()), 5);
        chk("E_rdy_full", 32'(rdy_viol), 0);
        chk("E_stable", 32'(stab_viol), 0);

        // Channel 2 user error, then a clean packet
        clear_q();
        add_flag(32'hDDC00264); pkt.push_back(8'h31); pkt.push_back(8'h32); pkt.push_back(8'h33);
        send(1, 1); idle(6);
        chk_cmd("F", 0, 32'h8000_0000, 2);
        chk_word("F", 0, 16'h3231, 2'b11, 0);
        chk_word("F", 1, 16'h0033, 2'b01, 1);
        chk_done("F", 1, 1);
        chk("F_err_cnt", 32'(err_cnt), 1);
        chk("F_drop", 32'(drop_cnt), 2);
        clear_q();
        add_flag(32'hDDC00264); pkt.push_back(8'h01); pkt.push_back(8'h02);
        send(1, 0); idle(6);
        chk_cmd("F2", 0, 32'h8000_0000, 2);
        chk_done("F2", 1, 0);

        // Reset in the middle of DATA with a word held in the output register
        clear_q();
        hold = 1;
        idle(2);
        add_flag(32'hDDC00264); pkt.push_back(8'h41); pkt.push_back(8'h42);
        send(0, 0);
        chk("R_pre_mvalid", 32'(m_valid), 1);
        chk("R_pre_mdata", 32'(m_data), 32'h4241);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("R_m_valid", 32'(m_valid), 0);
        chk("R_m_data", 32'(m_data), 0);
        chk("R_m_strb", 32'(m_strb), 0);
        chk("R_m_last", 32'(m_last), 0);
        chk("R_cmd_addr", cmd_addr, 0);
        chk("R_cmd_ch", 32'(cmd_ch), 0);
        chk("R_cmd_valid", 32'(cmd_valid), 0);
        chk("R_rdy", 32'(s_rx_ready), 0);
        chk("R_done", 32'(done_valid), 0);
        chk("R_err_cnt", 32'(err_cnt), 0);
        chk("R_drop_cnt", 32'(drop_cnt), 0);
        idle(2);
        sys_rst_n = 1'b1;
        hold = 0;
        idle(2);
        pkt.push_back(8'h43); pkt.push_back(8'h44);
        send(1, 0); idle(6);
        chk("R_tail_drop", 32'(drop_cnt), 1);
        chk("R_tail_words", 32'(wq_data.size()), 0);

        chk("end_rdy_full", 32'(rdy_viol), 0);
        chk("end_stable", 32'(stab_viol), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
